alu_seq: RTL and testbench

- Registered, handshaked successor to the team's 8-bit combinational ALU. Operand width is parametrised.
- Single-cycle logic and arithmetic ops, plus an optional iterative shift-add multiplier.
- Full status flags (carry, zero, negative, overflow, error) are registered alongside the result.
- Sits between the operand-fetch stage and writeback in the datapath, using valid/ready on both sides.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_mul.sv | 55 +++++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq block: opcode encodings, FSM state type
// and the registered flag bundle.
package alu_seq_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OPC_W-1:0] OP_GTU  = 4'd5;
    localparam logic [OPC_W-1:0] OP_SHLA = 4'd6;
    localparam logic [OPC_W-1:0] OP_SHLB = 4'd7;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH iterations after start. done is high for the cycle in which the
// product is complete; the owner must consume it on that edge.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(WIDTH);

    logic               busy_q;
    logic [WIDTH-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CNT_MAX);
    assign product = acc_q;

    // Load operands on start, then add/shift once per cycle until WIDTH steps are done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q && !done) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + 1'b1;
        end else if (done) begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU with status flags.
// Optional iterative multiplier (opcode 8) built only when ALU_SEQ_MUL_EN is
// defined; otherwise opcode 8 is reported as illegal.
//
// Handshake: an op transfers in when in_valid && in_ready, a result transfers
// out when out_valid && out_ready. in_ready is high only in IDLE with the output
// register free or draining this cycle, so an accept and a drain can share an
// edge. A stalled result (out_valid && !out_ready) holds out/out_hi/flags stable.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [OPC_W-1:0] opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag,
    output logic             err_flag
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             start_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] sc_res;
    flags_t           sc_flags;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    flags_t           flags_q;

    assign in_ready = rst_n && (state_q == ST_IDLE) && !mul_busy
                      && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   res_hi_q;

    assign start_mul = accept && (opcode == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (ina),
        .b       (inb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // High half of the product; cleared by every single-cycle result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_hi_q <= '0;
        end else if (accept && !start_mul) begin
            res_hi_q <= '0;
        end else if (mul_done) begin
            res_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
        end
    end

    assign out_hi = res_hi_q;
`else
    assign start_mul = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign out_hi    = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> MUL on a multiply accept, back when the product is ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-cycle datapath: result and flags for every non-multiply opcode.
    always_comb begin
        sc_res   = '0;
        sc_flags = '0;
        case (opcode)
            OP_ADD: begin
                {sc_flags.carry, sc_res} = {1'b0, ina} + {1'b0, inb};
                sc_flags.ovf = (ina[WIDTH-1] == inb[WIDTH-1])
                               && (sc_res[WIDTH-1] != ina[WIDTH-1]);
            end
            OP_SUB: begin
                {sc_flags.carry, sc_res} = {1'b0, ina} + {1'b0, ~inb} + (WIDTH+1)'(1);
                sc_flags.ovf = (ina[WIDTH-1] == ~inb[WIDTH-1])
                               && (sc_res[WIDTH-1] != ina[WIDTH-1]);
            end
            OP_AND:  sc_res = ina & inb;
            OP_OR:   sc_res = ina | inb;
            OP_XOR:  sc_res = ina ^ inb;
            OP_GTU:  sc_res = {{(WIDTH-1){1'b0}}, (ina > inb)};
            OP_SHLA: begin
                sc_res         = {ina[WIDTH-2:0], 1'b0};
                sc_flags.carry = ina[WIDTH-1];
            end
            OP_SHLB: begin
                sc_res         = {inb[WIDTH-2:0], 1'b0};
                sc_flags.carry = inb[WIDTH-1];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: sc_res = '0;
`endif
            default: sc_flags.err = 1'b1;
        endcase
        sc_flags.zero = (sc_res == '0);
        sc_flags.neg  = sc_res[WIDTH-1];
    end

    // Output register: load on single-cycle accept or multiply completion, else drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else if (accept && !start_mul) begin
            out_valid_q <= 1'b1;
            res_q       <= sc_res;
            flags_q     <= sc_flags;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (mul_done) begin
            out_valid_q   <= 1'b1;
            res_q         <= mul_prod[WIDTH-1:0];
            flags_q       <= '0;
            flags_q.zero  <= (mul_prod == '0);
            flags_q.neg   <= mul_prod[WIDTH-1];
        end
`endif
        else if (accept || (out_valid_q && out_ready)) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out        = res_q;
    assign carry_flag = flags_q.carry;
    assign zero_flag  = flags_q.zero;
    assign neg_flag   = flags_q.neg;
    assign ovf_flag   = flags_q.ovf;
    assign err_flag   = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases followed by
// random ops with random backpressure, compared against an arithmetic model.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ina;
    logic [W-1:0] inb;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         carry_flag;
    logic         zero_flag;
    logic         neg_flag;
    logic         ovf_flag;
    logic         err_flag;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ina        (ina),
        .inb        (inb),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_hi     (out_hi),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
        .ovf_flag   (ovf_flag),
        .err_flag   (err_flag)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Observed result bundle: {out_hi, out, carry, zero, neg, ovf, err}.
    function automatic logic [20:0] observed();
        return {out_hi, out, carry_flag, zero_flag, neg_flag, ovf_flag, err_flag};
    endfunction

    // Reference model from the op table using plain integer arithmetic.
    function automatic logic [20:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int     ua, ub, sa, sb, r;
        longint p;
        logic [7:0] o, h;
        bit c, v, e;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        o = 8'h00; h = 8'h00; c = 0; v = 0; e = 0;
        case (op)
            4'd0: begin
                r = ua + ub; o = r[7:0]; c = (r > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd1: begin
                r = ua - ub; o = r[7:0]; c = (ua >= ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = a ^ b;
            4'd5: o = (ua > ub) ? 8'd1 : 8'd0;
            4'd6: begin r = ua * 2; o = r[7:0]; c = (ua >= 128); end
            4'd7: begin r = ub * 2; o = r[7:0]; c = (ub >= 128); end
            4'd8: begin
                if (MUL_EN) begin
                    p = longint'(ua) * longint'(ub);
                    o = p[7:0];
                    h = p[15:8];
                end else begin
                    e = 1;
                end
            end
            default: e = 1;
        endcase
        return {h, o, c, ({h, o} == 16'h0000), o[7], v, e};
    endfunction

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_in_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Issue one op, check latency/result, hold the result for 'hold' stalled
    // cycles, then drain it unless 'keep' leaves it pending.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input bit keep);
        logic [20:0] exp;
        int lat, exp_lat, ir_seen;
        exp     = model(op, a, b);
        exp_lat = (op == 4'd8 && MUL_EN) ? W + 1 : 1;
        out_ready = (hold == 0) && !keep;
        wait_in_ready(tag);
        in_valid = 1'b1; opcode = op; ina = a; inb = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ina = 8'($urandom); inb = 8'($urandom); opcode = 4'($urandom);
        lat = 1; ir_seen = 0;
        while (!out_valid && lat < 3 * W) begin
            if (in_ready) ir_seen++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(observed()), 32'(exp));
        if (exp_lat > 1) chk({tag, "_busy_in_ready"}, 32'(ir_seen), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, 32'({out_valid, in_ready, observed()}),
                32'({1'b1, 1'b0, exp}));
        end
        if (!keep) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_drain"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ina = '0; inb = '0; opcode = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({out_valid, observed()}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed op-table cases
        do_op("add",      4'd0, 8'h55, 8'h1C, 0, 0);
        do_op("sub",      4'd1, 8'h1C, 8'h55, 0, 0);
        do_op("add_ovf",  4'd0, 8'h7F, 8'h01, 0, 0);
        do_op("sub_ovf",  4'd1, 8'h80, 8'h01, 0, 0);
        do_op("add_cy",   4'd0, 8'hFF, 8'h01, 0, 0);
        do_op("gtu",      4'd5, 8'h90, 8'h10, 0, 0);
        do_op("shlb",     4'd7, 8'h00, 8'hC0, 0, 0);
        do_op("mul_ff",   4'd8, 8'hFF, 8'hFF, 0, 0);
        do_op("mul_zero", 4'd8, 8'h00, 8'h37, 0, 0);

        // Backpressure, then a new accept in the same cycle as the drain
        do_op("xor_bp",   4'd4, 8'h55, 8'h1C, 5, 1);
        do_op("and_drain",4'd0 + 4'd2, 8'hF0, 8'h0F, 0, 0);

        // Illegal opcode, then a legal op clears err
        do_op("illegal12", 4'd12, 8'hA5, 8'h5A, 0, 0);
        do_op("after_ill", 4'd3, 8'h01, 8'h02, 0, 0);

        // Reset in the middle of a multiply (or a held result without the multiplier)
        out_ready = 1'b0;
        wait_in_ready("rst_mid");
        in_valid = 1'b1; opcode = 4'd8; ina = 8'hFF; inb = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_outputs", 32'({out_valid, observed()}), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
        do_op("shla_after_rst", 4'd6, 8'h81, 8'h00, 0, 0);

        // Random ops with occasional backpressure
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            int hold;
            op   = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op("rand", op, 8'($urandom), 8'($urandom), hold, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
